seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the board's 8-digit 7-segment display. Holds one segment pattern per digit in an internal register file written by the upstream game/datapath logic. Sequences the common-select and segment-enable lines digit by digit, with a programmable blanking gap to suppress ghosting. Sits between the top-level display datapath and the `oS_COM` / `oS_ENS` pins.

## Interface
- `N_DIGIT`, 8: number of scanned digits, legal range 1..8.
- `SCAN_DIV`, 2500: clock cycles per digit slot, ≥ 2.
- `BLANK`, 1: blanking cycles at the start of each slot, 0 ≤ `BLANK` < `SCAN_DIV`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  reset. Synchronous and active-high, despite the name: `nrst`=1 at a rising edge resets the block.
- `en`  in  1  scan enable; 0 blanks the display and freezes the scan.
- `wr_en`  in  1  digit write strobe, one write per asserted cycle.
- `wr_addr`  in  3  digit index to write.
- `wr_data`  in  8  segment pattern, bit i = segment i, active-high.
- `o_com`  out  8  digit select, active-low one-hot; 8'hFF = none.
- `o_ens`  out  8  segment enables, active-high.
- `o_frame`  out  1  single-cycle pulse at each frame wrap.

## Operation
- **Register file.** `digit[0..N_DIGIT-1]` holds 8 bits each.
  - A write with `wr_en`=1 and `wr_addr` < `N_DIGIT` updates `digit[wr_addr]` at that edge.
  - A write with `wr_addr` ≥ `N_DIGIT` is ignored.
  - Writes are always accepted: no ready/ack, and independent of `en`.
- **Scan state.**
  - Slot counter `cnt`: 0..`SCAN_DIV`-1.
  - Digit index `idx`: 0..`N_DIGIT`-1.
  - Shadow pattern `shd`: 8 bits.
- **Slot advance.** With `en`=1 each edge advances `cnt`. Leaving `cnt`=`SCAN_DIV`-1:
  - `cnt` returns to 0.
  - `idx` advances, wrapping from `N_DIGIT`-1 to 0.
- **Shadow load.** On every edge that enters `cnt`=0, `shd` loads `digit[new idx]` using the pre-edge value. A write on that same edge is not shown until that digit's next slot.
- **Output decode.** Outputs are registers loaded with the value for the cycle being entered:
  - `cnt` < `BLANK`: `o_com`=8'hFF, `o_ens`=8'h00.
  - Otherwise: `o_com` = ~(1<<`idx`), `o_ens` = `shd`.
- **o_frame.** 1 on the edge where `idx` wraps from `N_DIGIT`-1 to 0, else 0. It does not fire on the first slot after reset. With `N_DIGIT`=1 it fires at every slot start.
- **en=0.**
  - Next edge: `o_com`=8'hFF, `o_ens`=8'h00, `o_frame`=0.
  - `idx` and `digit[]` hold.
- **en rising.** The first edge with `en`=1 restarts the current `idx` at `cnt`=0: full blanking, `shd` reloaded. No `o_frame` pulse.

## Timing
- **Reset.** On an edge with `nrst`=1:
  - `o_com`=8'hFF, `o_ens`=8'h00, `o_frame`=0.
  - `cnt`=0, `idx`=0, `shd`=0, all `digit[]`=0.
  - Reset has priority over `en` and `wr_en`.
  - Reset mid-slot or mid-frame abandons the scan immediately.
- **First slot.** The first edge with `nrst`=0 and `en`=1 begins slot 0 of digit 0 (`cnt`=0).
- **Slot and frame length.**
  - Each slot lasts exactly `SCAN_DIV` cycles: `BLANK` blank, then `SCAN_DIV`-`BLANK` lit.
  - A frame lasts `N_DIGIT`·`SCAN_DIV` cycles while `en` stays 1.
- **Write latency.** Write-to-display latency is between 1 and `N_DIGIT`·`SCAN_DIV` cycles. It is always taken at the target digit's next slot start after the write edge.
- **BLANK=0.** The digit is lit from `cnt`=0, with no dead cycle between digits.
- **Overlap rule.** No two `o_com` bits are ever low in the same cycle, including across `idx` wrap and `en` toggles.

## Test plan
Benches use `N_DIGIT`=8, `SCAN_DIV`=4, `BLANK`=1 unless stated.
1. **Reset values.** Hold `nrst`=1 for 2 edges, then release with `en`=1 → `o_com`=8'hFF, `o_ens`=8'h00 for 1 cycle. Then `o_com`=8'hFE with `o_ens`=8'h00 for 3 cycles. Then blank 1 cycle, then `o_com`=8'hFD.
2. **Full frame.** Write `digit[i]`=8'h10+i for all i, then run ≥2 frames → each slot shows `o_com`=~(1<<i) with `o_ens`=8'h10+i for 3 of 4 cycles. `o_frame` pulses once every 32 cycles, coincident with the `idx` 7→0 edge.
3. **Same-edge write.** Write `digit[3]`=8'hAA on the edge entering slot 3 (old value 8'h13) → slot shows 8'h13. The next frame's slot 3 shows 8'hAA. A write of 8'h55 to `wr_addr`=3 mid-slot leaves the current `o_ens` unchanged.
4. **Enable pause.** Drop `en` at `idx`=5, `cnt`=2 for 6 cycles, then raise it → blank during the pause. Resume at `idx`=5 with 1 blank and 3 lit cycles. No `o_frame` pulse.
5. **Mid-scan reset.** Assert `nrst` for 1 edge at `idx`=6 → outputs return to reset values on that edge and all `digit[]` read back as 0. The scan restarts at `idx`=0.
6. **Variant config.** With `N_DIGIT`=4, `BLANK`=0, `SCAN_DIV`=2, a write to `wr_addr`=6 is ignored. `o_com` cycles FE,FE,FD,FD,FB,FB,F7,F7 with no blank cycles. `o_frame` pulses every 8 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// SegScanCtrl -- time-multiplexing scan controller for an up-to-8-digit
// 7-segment display.
//
// Holds one segment pattern per digit in a small register file and scans
// the digits one slot at a time. Each slot starts with a blanking gap to
// suppress ghosting. Every output is a register.
//
// Parameters
//   N_DIGIT  : number of scanned digits (1..8)
//   SCAN_DIV : clock cycles per digit slot (>= 2)
//   BLANK    : blanked cycles at the start of each slot (0..SCAN_DIV-1)
//
// Ports
//   clk      : system clock, rising edge
//   nrst     : synchronous reset, ACTIVE-HIGH despite the name
//   en       : scan enable; low blanks the display and freezes the scan
//   wr_en    : digit write strobe
//   wr_addr  : digit index to write (writes at or above N_DIGIT are ignored)
//   wr_data  : segment pattern, bit i = segment i, active-high
//   o_com    : digit select, active-low one-hot (8'hFF = no digit)
//   o_ens    : segment enables, active-high
//   o_frame  : one-cycle pulse when the scan wraps from the last digit to 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int N_DIGIT  = 8,
    parameter int SCAN_DIV = 2500,
    parameter int BLANK    = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] o_com,
    output logic [7:0] o_ens,
    output logic       o_frame
);

    localparam int              CNTW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(N_DIGIT - 1);

    // ST_IDLE: scan not running (after reset or while en is low).
    // ST_SCAN: scan advancing one count per cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [2:0]      idx_q,   idx_d;
    logic [7:0]      shd_q,   shd_d;
    logic [7:0]      com_q,   com_d;
    logic [7:0]      ens_q,   ens_d;
    logic            frame_q, frame_d;

    // Eight entries regardless of N_DIGIT. Entries at or above N_DIGIT are
    // never written and never selected, because idx stays below N_DIGIT.
    logic [7:0]      digit_q [8];

    assign o_com   = com_q;
    assign o_ens   = ens_q;
    assign o_frame = frame_q;

    // Digit register file. Writes are accepted whenever strobed, whatever
    // the scan state.
    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= 8'h00;
            end
        end else if (wr_en && (int'(wr_addr) < N_DIGIT)) begin
            digit_q[wr_addr] <= wr_data;
        end
    end

    // Scan state and output registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shd_q   <= 8'h00;
            com_q   <= 8'hFF;
            ens_q   <= 8'h00;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shd_q   <= shd_d;
            com_q   <= com_d;
            ens_q   <= ens_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic and output decode.
    // The shadow register reads digit_q before this edge's write takes
    // effect. A write that lands on a slot-start edge is therefore shown
    // only at that digit's next slot.
    // Leaving ST_IDLE restarts the current digit at cnt=0, so every
    // resume begins with a full blanking gap and never pulses o_frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shd_d   = shd_q;
        com_d   = 8'hFF;
        ens_d   = 8'h00;
        frame_d = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_SCAN;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    shd_d = digit_q[idx_q];
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = 3'd0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                        shd_d = digit_q[idx_d];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase

            if (int'(cnt_d) >= BLANK) begin
                com_d = ~(8'd1 << idx_d);
                ens_d = shd_d;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl -- self-checking bench for seg_scan_ctrl.
//
// Drives two instances from shared stimulus:
//   instance 0: N_DIGIT=8, SCAN_DIV=4, BLANK=1
//   instance 1: N_DIGIT=4, SCAN_DIV=2, BLANK=0
//
// The reference model tracks each instance's position within a frame, in
// cycles. The digit, slot phase and frame wrap all follow from that
// position by division and modulo.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] comA, ensA, comB, ensB;
    logic       frameA, frameB;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.N_DIGIT(8), .SCAN_DIV(4), .BLANK(1)) dutA (
        .clk(clk), .nrst(nrst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .o_com(comA), .o_ens(ensA), .o_frame(frameA)
    );

    seg_scan_ctrl #(.N_DIGIT(4), .SCAN_DIV(2), .BLANK(0)) dutB (
        .clk(clk), .nrst(nrst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .o_com(comB), .o_ens(ensB), .o_frame(frameB)
    );

    int cfgN  [2] = '{8, 4};
    int cfgSD [2] = '{4, 2};
    int cfgBL [2] = '{1, 0};

    // Reference model state, one set per instance.
    int         mPos  [2];
    bit         mRun  [2];
    logic [7:0] mShd  [2];
    logic [7:0] mDig  [2][8];
    logic [7:0] expCom   [2];
    logic [7:0] expEns   [2];
    logic       expFrame [2];

    int vectors = 0;
    int miscompares = 0;

    // Advance the model by one clock edge, using the inputs that the DUTs
    // sampled on that edge.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int n  = cfgN[k];
            int sd = cfgSD[k];
            int bl = cfgBL[k];
            int slot;
            logic [7:0] sel;
            if (nrst) begin
                mPos[k] = 0;
                mRun[k] = 1'b0;
                mShd[k] = 8'h00;
                for (int i = 0; i < 8; i++) mDig[k][i] = 8'h00;
                expCom[k]   = 8'hFF;
                expEns[k]   = 8'h00;
                expFrame[k] = 1'b0;
            end else begin
                if (en) begin
                    if (!mRun[k]) begin
                        mPos[k]     = (mPos[k] / sd) * sd;
                        mShd[k]     = mDig[k][mPos[k] / sd];
                        expFrame[k] = 1'b0;
                    end else begin
                        mPos[k]     = (mPos[k] + 1) % (n * sd);
                        expFrame[k] = (mPos[k] == 0);
                        if (mPos[k] % sd == 0) mShd[k] = mDig[k][mPos[k] / sd];
                    end
                    mRun[k] = 1'b1;
                    slot = mPos[k] / sd;
                    if (mPos[k] % sd < bl) begin
                        expCom[k] = 8'hFF;
                        expEns[k] = 8'h00;
                    end else begin
                        sel       = 8'd1 << slot;
                        expCom[k] = ~sel;
                        expEns[k] = mShd[k];
                    end
                end else begin
                    mRun[k]     = 1'b0;
                    expCom[k]   = 8'hFF;
                    expEns[k]   = 8'h00;
                    expFrame[k] = 1'b0;
                end
                if (wr_en && (int'(wr_addr) < n)) mDig[k][wr_addr] = wr_data;
            end
        end
    endtask

    task automatic checkOutput();
        logic [7:0] oc, oe;
        logic       of;
        vectors++;
        for (int k = 0; k < 2; k++) begin
            oc = (k == 0) ? comA   : comB;
            oe = (k == 0) ? ensA   : ensB;
            of = (k == 0) ? frameA : frameB;
            assert (oc === expCom[k]) else begin
                miscompares++;
                $error("[TB] FAIL dut%0d.o_com at vector %0d: observed %h expected %h", k, vectors, oc, expCom[k]);
            end
            assert (oe === expEns[k]) else begin
                miscompares++;
                $error("[TB] FAIL dut%0d.o_ens at vector %0d: observed %h expected %h", k, vectors, oe, expEns[k]);
            end
            assert (of === expFrame[k]) else begin
                miscompares++;
                $error("[TB] FAIL dut%0d.o_frame at vector %0d: observed %b expected %b", k, vectors, of, expFrame[k]);
            end
            assert ($countones(~oc) <= 1) else begin
                miscompares++;
                $error("[TB] FAIL dut%0d.overlap at vector %0d: observed o_com %h expected at most one low bit", k, vectors, oc);
            end
        end
    endtask

    // Apply one cycle of inputs, clock, update the model, then check #1
    // after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic w,
                                 input logic [2:0] a, input logic [7:0] d);
        nrst    = r;
        en      = e;
        wr_en   = w;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Run instance 0 with en=1 until its frame position reaches target.
    task automatic runToPos(input int target);
        for (int i = 0; i < 64; i++) begin
            if (mPos[0] == target) break;
            applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        end
    endtask

    initial begin
        // Reset values, then the first slots after release.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Load distinct patterns and scan more than two full frames.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 3'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Write on the edge that enters slot 3, then mid-slot.
        runToPos(11);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 8'hAA);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 8'h55);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 8'hAA);
        for (int i = 0; i < 36; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Write to an address beyond the small instance's range.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 8'hC3);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Pause the scan at digit 5, count 2.
        runToPos(21);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Mid-scan reset while showing digit 6.
        runToPos(25);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'h77);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Randomised traffic: writes, enable drops and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)),
                          8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
